// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port 256x16 data memory: CPU (MEM stage) vs debug/loader.
// One transaction at a time: grant in IDLE, one WR cycle or READ_WAIT RD cycles, then a DONE ack cycle.
module dmem_port_arbiter #(
  parameter int READ_WAIT    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hlt,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] rd_data,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_w_en,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it until its ack,
  // which is a single-cycle pulse in DONE; req may drop or change at the edge closing that cycle.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int RW_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RW_W-1:0] RD_LOAD    = RW_W'(READ_WAIT - 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [1:0]      state;
  logic            owner_dbg;
  logic [RW_W-1:0] rd_cnt;
  logic [SC_W-1:0] starve;

  logic        cpu_elig;
  logic        grant_dbg;
  logic        grant_any;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;

  // DBG wins when the CPU cannot, or when the CPU has had STARVE_LIMIT grants in a row over it.
  assign cpu_elig  = cpu_req & ~hlt;
  assign grant_dbg = dbg_req & (~cpu_elig | (starve == STARVE_MAX));
  assign grant_any = grant_dbg | cpu_elig;
  assign sel_we    = grant_dbg ? dbg_we    : cpu_we;
  assign sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
  assign sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner_dbg <= 1'b0;
      rd_cnt    <= '0;
      starve    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner_dbg <= grant_dbg;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            rd_cnt    <= RD_LOAD;
            state     <= sel_we ? S_WR : S_RD;
          end
          if (grant_dbg || !dbg_req) begin
            starve <= '0;
          end else if (grant_any && (starve != STARVE_MAX)) begin
            starve <= starve + 1'b1;
          end
        end
        S_WR: begin
          state <= S_DONE;
        end
        S_RD: begin
          // mem_addr has been stable for READ_WAIT cycles at the edge where rd_cnt is zero.
          if (rd_cnt == '0) begin
            rd_data <= mem_rdata;
            state   <= S_DONE;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded from state so that an asynchronous reset drops them without waiting for an edge.
  assign busy     = (state != S_IDLE);
  assign mem_w_en = (state == S_WR);
  assign cpu_ack  = (state == S_DONE) && !owner_dbg;
  assign dbg_ack  = (state == S_DONE) &&  owner_dbg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, multi-cycle corner sequences,
// then random traffic against a transaction-level reference model.
module tb_dmem_port_arbiter;

  localparam int RW = 5;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hlt;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack, dbg_ack, mem_w_en, busy;
  logic [15:0] rd_data, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic        mem_load;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  int total = 0;
  int bad   = 0;

  dmem_port_arbiter #(.READ_WAIT(RW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Clock / memory model
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a ^ 8'h5a, ~a};
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
    end else if (mem_w_en) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_req(input logic who_dbg, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata);
    if (who_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_load = 1'b1;
    cpu_req = 1'b0; dbg_req = 1'b0; hlt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_load = 1'b0; rst_n = 1'b1;
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in the following IDLE cycle.
  task automatic run_txn(input logic who_dbg, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata, output int lat, output logic [15:0] rd,
                         output int wen_cnt, output logic other_ack, output logic addr_ok);
    logic got;
    drive_req(who_dbg, we, addr, wdata);
    got = 1'b0; lat = -1; rd = '0; wen_cnt = 0; other_ack = 1'b0; addr_ok = 1'b1;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (mem_w_en) wen_cnt++;
      if (busy && mem_addr != addr) addr_ok = 1'b0;
      if (who_dbg ? cpu_ack : dbg_ack) other_ack = 1'b1;
      if (who_dbg ? dbg_ack : cpu_ack) begin
        got = 1'b1; lat = n; rd = rd_data;
      end
    end
    if (who_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        who_dbg;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs[10];

  // Reference model state for the random phase
  int          m_cnt;
  int          m_starve;
  logic        m_owner_dbg, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_pend, rd_exp;

  initial begin
    int          lat, wen_cnt, c_at, d_at, c_cnt, acks;
    logic [15:0] rd;
    logic        other_ack, addr_ok, cpu_el, g_dbg;
    logic        order[$];
    logic        exp_order[10];

    vecs[0] = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 2,      16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 16'h0000, RW + 1, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 8'h20, 16'h1234, 2,      16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 8'h20, 16'h0000, RW + 1, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 8'h10, 16'h0000, RW + 1, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 16'h0000, RW + 1, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 16'hA5A5, 2,      16'hBEEF};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 16'h0000, RW + 1, 16'hA5A5};
    vecs[8] = '{1'b1, 1'b1, 8'h00, 16'h0F0F, 2,      16'hA5A5};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 16'h0000, RW + 1, 16'h0F0F};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req = 1'b0; dbg_req = 1'b0; hlt = 1'b0;
    rst_n = 1'b0; mem_load = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_w_en", 32'(mem_w_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    mem_load = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Vector table: single transactions from IDLE
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].who_dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              lat, rd, wen_cnt, other_ack, addr_ok);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_rd_data", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_w_en_cycles", i), 32'(wen_cnt), vecs[i].we ? 32'd1 : 32'd0);
      check($sformatf("v%0d_other_ack", i), 32'(other_ack), 32'd0);
      check($sformatf("v%0d_addr_stable", i), 32'(addr_ok), 32'd1);
      if (vecs[i].we) check($sformatf("v%0d_mem", i), 32'(mem[vecs[i].addr]), 32'(vecs[i].wdata));
    end

    // Simultaneous requests: CPU first, DBG in the next IDLE
    drive_req(1'b0, 1'b1, 8'h60, 16'h6060);
    drive_req(1'b1, 1'b1, 8'h61, 16'h6161);
    c_at = -1; d_at = -1;
    for (int n = 1; n <= 20 && d_at < 0; n++) begin
      @(negedge clk);
      if (cpu_ack) begin c_at = n; cpu_req = 1'b0; end
      if (dbg_ack) begin d_at = n; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("sim_cpu_ack_at", 32'(c_at), 32'd2);
    check("sim_dbg_ack_at", 32'(d_at), 32'd5);
    @(negedge clk);
    check("sim_mem_cpu", 32'(mem[8'h60]), 32'h6060);
    check("sim_mem_dbg", 32'(mem[8'h61]), 32'h6161);

    // Starvation: both held continuously, DBG gets every fifth grant
    drive_req(1'b0, 1'b1, 8'h40, 16'h4040);
    drive_req(1'b1, 1'b1, 8'h41, 16'h4141);
    for (int n = 0; n < 200 && order.size() < 10; n++) begin
      @(negedge clk);
      if (cpu_ack) order.push_back(1'b0);
      if (dbg_ack) order.push_back(1'b1);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("starve_ack_count", 32'(order.size()), 32'd10);
    for (int i = 0; i < order.size() && i < 10; i++)
      check($sformatf("starve_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    @(negedge clk);

    // Halt: only DBG served until hlt falls
    hlt = 1'b1;
    drive_req(1'b0, 1'b1, 8'h50, 16'h5050);
    drive_req(1'b1, 1'b1, 8'h51, 16'h5151);
    c_cnt = 0; d_at = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (cpu_ack) c_cnt++;
      if (dbg_ack) begin d_at = n; dbg_req = 1'b0; end
    end
    check("hlt_dbg_ack_at", 32'(d_at), 32'd2);
    check("hlt_cpu_acks", 32'(c_cnt), 32'd0);
    hlt = 1'b0;
    c_at = -1;
    for (int n = 1; n <= 20 && c_at < 0; n++) begin
      @(negedge clk);
      if (cpu_ack) begin c_at = n; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
    check("hlt_release_cpu_ack_at", 32'(c_at), 32'd2);
    @(negedge clk);

    // Reset during WR
    drive_req(1'b0, 1'b1, 8'h30, 16'hDEAD);
    @(negedge clk);
    check("rwr_w_en_before", 32'(mem_w_en), 32'd1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("rwr_w_en_drop", 32'(mem_w_en), 32'd0);
    check("rwr_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rwr_mem_unchanged", 32'(mem[8'h30]), 32'(pat(8'h30)));
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    check("rwr_no_ack", 32'(acks), 32'd0);
    check("rwr_idle", 32'(busy), 32'd0);

    // Random traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
    m_cnt = 0; m_starve = 0; m_owner_dbg = 1'b0; m_we = 1'b0;
    m_addr = '0; m_pend = '0; rd_exp = '0;
    for (int cyc = 0; cyc < 2040; cyc++) begin
      @(negedge clk);
      check("r_busy", 32'(busy), 32'(m_cnt > 0));
      check("r_cpu_ack", 32'(cpu_ack), 32'(m_cnt == 1 && !m_owner_dbg));
      check("r_dbg_ack", 32'(dbg_ack), 32'(m_cnt == 1 && m_owner_dbg));
      check("r_w_en", 32'(mem_w_en), 32'(m_cnt == 2 && m_we));
      check("r_rd_data", 32'(rd_data), 32'(rd_exp));
      if (m_cnt > 0) check("r_mem_addr", 32'(mem_addr), 32'(m_addr));

      if (m_cnt == 1) begin
        if (m_owner_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
      if (cyc < 2000) begin
        if (!cpu_req && $urandom_range(0, 2) == 0)
          drive_req(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
        if (!dbg_req && $urandom_range(0, 2) == 0)
          drive_req(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
        if ($urandom_range(0, 9) == 0) hlt = ~hlt;
      end else begin
        hlt = 1'b0;
      end

      if (m_cnt > 0) begin
        if (m_cnt == 2 && !m_we) rd_exp = m_pend;
        m_cnt--;
      end else begin
        cpu_el = cpu_req && !hlt;
        g_dbg  = dbg_req && (!cpu_el || m_starve == SL);
        if (g_dbg || cpu_el) begin
          m_owner_dbg = g_dbg;
          m_we   = g_dbg ? dbg_we : cpu_we;
          m_addr = g_dbg ? dbg_addr : cpu_addr;
          m_cnt  = m_we ? 2 : RW + 1;
          if (m_we) ref_mem[m_addr] = g_dbg ? dbg_wdata : cpu_wdata;
          else      m_pend = ref_mem[m_addr];
        end
        if (g_dbg || !dbg_req) m_starve = 0;
        else if (cpu_el && m_starve < SL) m_starve++;
      end
    end
    check("r_drained", 32'(m_cnt), 32'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("r_mem%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
